// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types for the backlight fade sequencer.
package pwm_fade_ctrl_pkg;

  typedef logic [15:0] byte2_t;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RAMP = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_period_timer.sv
// Free-running PWM period counter; period_tick is high on the last cycle of every period.
module pwm_period_timer
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  localparam byte2_t LAST = byte2_t'(PERIOD - 1);

  byte2_t cnt_q, cnt_d;
  logic   tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
  end

  // Tick is registered from the next count so it lines up with count == PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign period_tick = tick_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: ramps the PWM high time toward a commanded target, one step every
// STEP_PERIODS period boundaries, keeping t_high + t_low == PERIOD.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cmd_valid,
  output logic   cmd_ready,
  input  byte2_t cmd_target,
  input  byte2_t cmd_step,
  output byte2_t t_high,
  output byte2_t t_low,
  output logic   period_tick,
  output logic   busy,
  output logic   done
);

  if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
    $error("pwm_fade_ctrl: PERIOD must be in 2..65535");
  end
  if (STEP_PERIODS < 1) begin : g_bad_step
    $error("pwm_fade_ctrl: STEP_PERIODS must be >= 1");
  end

  localparam byte2_t TMAX = byte2_t'(PERIOD - 1);
  localparam byte2_t TPER = byte2_t'(PERIOD);
  localparam byte2_t HALF = byte2_t'(PERIOD / 2);
  localparam int     SCW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(STEP_PERIODS - 1);

  // Keeps both PWM phases at least one cycle long.
  function automatic byte2_t clamp_tgt(input byte2_t v);
    if (v == '0)       return byte2_t'(1);
    else if (v > TMAX) return TMAX;
    else               return v;
  endfunction

  // One saturating step toward tgt, evaluated in 17 bits so nothing wraps.
  function automatic byte2_t step_toward(input byte2_t cur, input byte2_t tgt, input byte2_t stp);
    logic [16:0] sum;
    if (cur < tgt) begin
      sum = {1'b0, cur} + {1'b0, stp};
      return (sum >= {1'b0, tgt}) ? tgt : sum[15:0];
    end else begin
      sum = {1'b0, tgt} + {1'b0, stp};
      return ({1'b0, cur} <= sum) ? tgt : cur - stp;
    end
  endfunction

  fade_state_t     state_q, state_d;
  byte2_t          tgt_q, tgt_d;
  byte2_t          stp_q, stp_d;
  byte2_t          th_q, th_d;
  byte2_t          tl_q, tl_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic            done_q, done_d;
  logic            tick;
  byte2_t          tgt_in;
  byte2_t          th_step;

  pwm_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (tick)
  );

  assign tgt_in  = clamp_tgt(cmd_target);
  assign th_step = step_toward(th_q, tgt_q, stp_q);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    th_d    = th_q;
    tl_d    = tl_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    case (state_q)
      FADE_IDLE: begin
        if (cmd_valid) begin
          tgt_d   = tgt_in;
          stp_d   = (cmd_step == '0) ? byte2_t'(1) : cmd_step;
          scnt_d  = '0;
          state_d = FADE_RAMP;
          done_d  = (tgt_in == th_q);
        end
      end
      FADE_RAMP: begin
        // The done cycle is the last RAMP cycle; no further stepping happens in it.
        if (done_q) begin
          state_d = FADE_IDLE;
        end else if (tick) begin
          if (scnt_q == SC_LAST) begin
            scnt_d = '0;
            th_d   = th_step;
            tl_d   = TPER - th_step;
            done_d = (th_step == tgt_q);
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = FADE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FADE_IDLE;
      tgt_q   <= '0;
      stp_q   <= '0;
      th_q    <= HALF;
      tl_q    <= TPER - HALF;
      scnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
      scnt_q  <= scnt_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready   = (state_q == FADE_IDLE);
  assign busy        = (state_q == FADE_RAMP);
  assign done        = done_q;
  assign t_high      = th_q;
  assign t_low       = tl_q;
  assign period_tick = tick;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Randomized bench for pwm_fade_ctrl against a transaction-level fade model.
module tb_pwm_fade_ctrl;
  import pwm_fade_ctrl_pkg::*;

  localparam int P  = 10;
  localparam int SP = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   cmd_valid = 1'b0;
  logic   cmd_ready;
  byte2_t cmd_target = '0;
  byte2_t cmd_step = '0;
  byte2_t t_high, t_low;
  logic   period_tick, busy, done;

  pwm_fade_ctrl #(.PERIOD(P), .STEP_PERIODS(SP)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .t_high      (t_high),
    .t_low       (t_low),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: current duty, pending duty values of the ramp, ticks since accept.
  int m_th, m_ticks, m_cyc;
  bit m_ready, m_done, acc;
  int q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_th = P / 2; m_ready = 1; m_done = 0; m_cyc = 0; m_ticks = 0;
    q.delete();
  endtask

  task automatic check_outputs();
    chk("t_high", int'(t_high), m_th);
    chk("t_low", int'(t_low), P - m_th);
    chk("period_tick", int'(period_tick), int'(m_cyc % P == P - 1));
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    chk("busy", int'(busy), int'(!m_ready));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic model_accept(input int tgt_raw, input int stp_raw);
    int tgt, stp, v;
    tgt = (tgt_raw < 1) ? 1 : (tgt_raw > P - 1) ? P - 1 : tgt_raw;
    stp = (stp_raw < 1) ? 1 : stp_raw;
    v = m_th;
    q.delete();
    while (v != tgt) begin
      if (v < tgt) v = (v + stp >= tgt) ? tgt : v + stp;
      else         v = (v - stp <= tgt) ? tgt : v - stp;
      q.push_back(v);
    end
    m_ticks = 0;
    m_ready = 0;
    m_done  = (q.size() == 0);
  endtask

  task automatic cycle();
    bit tick_now, was_done;
    tick_now = (m_cyc % P == P - 1);
    was_done = m_done;
    acc = 0;
    m_done = 0;
    if (m_ready) begin
      if (cmd_valid) begin
        model_accept(int'(cmd_target), int'(cmd_step));
        acc = 1;
      end
    end else if (was_done) begin
      m_ready = 1;
    end else if (tick_now) begin
      m_ticks++;
      if (m_ticks % SP == 0 && q.size() > 0) begin
        m_th = q.pop_front();
        m_done = (q.size() == 0);
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  task automatic send(input int tgt, input int stp);
    int n;
    cmd_target = byte2_t'(tgt);
    cmd_step   = byte2_t'(stp);
    cmd_valid  = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 400);
    chk("accept_timeout", int'(acc), 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!cmd_ready && n < limit) begin
      cycle();
      n++;
    end
    chk("idle_timeout", int'(cmd_ready), 1);
  endtask

  initial begin
    do_reset(3);
    repeat (3) cycle();

    send(8, 1);   wait_idle(400);
    send(0, 3);   wait_idle(400);
    send(20, 0);  wait_idle(400);
    send(9, 2);   wait_idle(400);   // target equals current duty

    send(3, 1);
    send(7, 2);                     // held through the first ramp
    wait_idle(400);

    send(1, 1);
    repeat (15) cycle();
    do_reset(1);
    repeat (4) cycle();

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 5)) cycle();
      send(int'($urandom_range(0, 20)), int'($urandom_range(0, 5)));
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(1, 40)) cycle();
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 9) < 7) begin
        wait_idle(400);
      end
    end
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
